// File: rtl/demux1x4_stream_if.sv
// Stream bundle for the 1-to-4 demux: one input lane, four output lanes.
// out_cnt is present only when DEMUX_CNT_EN is defined.
interface demux1x4_stream_if #(
  parameter int W  = 2,
  parameter int CW = 8
);
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
`ifdef DEMUX_CNT_EN
  logic [4*CW-1:0] out_cnt;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_cnt
  );
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_cnt
  );
`else
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
`endif

  if (W < 1 || CW < 1) begin : g_bad_param
    $error("demux1x4_stream_if: W and CW must be >= 1");
  end
endinterface

// File: rtl/demux1x4_stream.sv
// 1-to-4 stream demux, one registered slot per channel.
// Optional per-channel load counters under DEMUX_CNT_EN.
module demux1x4_stream #(
  parameter int W  = 2,
  parameter int CW = 8
) (
  input logic clk,
  input logic rst_n,
  demux1x4_stream_if.slave s
);
  logic [3:0]   full;
  logic [3:0]   load;
  logic [3:0]   drain;
  logic [W-1:0] data_q [4];
  logic         rdy;

  // A slot can take a new beat if empty or emptying this cycle
  assign rdy = rst_n
             & (~full[s.in_sel] | s.out_ready[s.in_sel]);
  assign s.in_ready  = rdy;
  assign s.out_valid = full;

  always_comb begin
    load  = '0;
    drain = full & s.out_ready;
    for (int k = 0; k < 4; k++) begin
      load[k] = s.in_valid & rdy
              & (s.in_sel == 2'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k] <= s.in_data;
          full[k]   <= 1'b1;
        end else if (drain[k]) begin
          full[k]   <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    s.out_data = '0;
    for (int k = 0; k < 4; k++) begin
      s.out_data[k*W +: W] = data_q[k];
    end
  end

`ifdef DEMUX_CNT_EN
  logic [CW-1:0] cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          cnt[k] <= cnt[k] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    s.out_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      s.out_cnt[k*CW +: CW] = cnt[k];
    end
  end
`endif

  if (W < 1 || CW < 1) begin : g_bad_param
    $error("demux1x4_stream: W and CW must be >= 1");
  end
endmodule

// File: tb/tb_demux1x4_stream.sv
// Bench for demux1x4_stream: directed scenarios plus a
// randomized run against a queue-based channel model.
module tb_demux1x4_stream;
  localparam int W  = 2;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  demux1x4_stream_if #(.W(W), .CW(CW)) bus ();

  demux1x4_stream #(.W(W), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [1:0] sel, input logic [W-1:0] d,
                       input logic v, input logic [3:0] r);
    @(negedge clk);
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.in_valid  = v;
    bus.out_ready = r;
    #1;
  endtask

  task automatic test_reset;
    bus.in_sel = 0; bus.in_data = 0;
    bus.in_valid = 0; bus.out_ready = 0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0000", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", bus.out_data);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(2'(k), '0, 1'b0, 4'h0);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_ready sel=%0d got=%b exp=1", k, bus.in_ready);
      end
    end
  endtask

  task automatic test_routing;
    logic [1:0]   sels [4];
    logic [W-1:0] dats [4];
    sels = '{2'd0, 2'd1, 2'd2, 2'd3};
    dats = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(sels[i], dats[i], 1'b1, 4'hF);
      else       drive(2'd0, '0, 1'b0, 4'hF);
      if (i < 4) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL route_ready beat=%0d got=%b exp=1", i, bus.in_ready);
        end
      end
      if (i > 0) begin
        checks++;
        if (bus.out_valid !== (4'b0001 << sels[i-1])) begin
          errors++;
          $display("FAIL route_valid beat=%0d got=%b exp=%b",
                   i - 1, bus.out_valid, 4'b0001 << sels[i-1]);
        end
        checks++;
        if (bus.out_data[sels[i-1]*W +: W] !== dats[i-1]) begin
          errors++;
          $display("FAIL route_data beat=%0d got=%b exp=%b",
                   i - 1, bus.out_data[sels[i-1]*W +: W], dats[i-1]);
        end
      end
    end
    drive(2'd0, '0, 1'b0, 4'hF);
  endtask

  task automatic test_backpressure;
    logic [1:0]   er [4];
    logic [W-1:0] ed [4];
    logic [3:0]   r  [4];
    er = '{2'b01, 2'b00, 2'b00, 2'b01};
    ed = '{2'b11, 2'b11, 2'b11, 2'b01};
    r  = '{4'b1011, 4'b1011, 4'b1011, 4'b1111};
    drive(2'd2, 2'b11, 1'b1, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_first_ready got=%b exp=1", bus.in_ready);
        end
      end
      if (i < 3) drive(2'd2, 2'b01, 1'b1, r[i+1]);
      else       drive(2'd0, '0, 1'b0, 4'hF);
      if (i < 3) begin
        checks++;
        if (bus.in_ready !== er[i+1][0]) begin
          errors++;
          $display("FAIL bp_ready step=%0d got=%b exp=%b",
                   i, bus.in_ready, er[i+1][0]);
        end
      end
      checks++;
      if (bus.out_valid[2] !== 1'b1 || bus.out_data[2*W +: W] !== ed[i]) begin
        errors++;
        $display("FAIL bp_hold step=%0d got=%b/%b exp=1/%b",
                 i, bus.out_valid[2], bus.out_data[2*W +: W], ed[i]);
      end
    end
    drive(2'd0, '0, 1'b0, 4'hF);
    checks++;
    if (bus.out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL bp_empty got=%b exp=0000", bus.out_valid);
    end
  endtask

  task automatic test_independence;
    drive(2'd1, 2'b11, 1'b1, 4'b1101);
    drive(2'd0, 2'b10, 1'b1, 4'b1101);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ind_ready0 got=%b exp=1", bus.in_ready);
    end
    drive(2'd3, 2'b01, 1'b1, 4'b1101);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_data[0 +: W] !== 2'b10) begin
      errors++;
      $display("FAIL ind_ready3 got=%b/%b exp=1/10",
               bus.in_ready, bus.out_data[0 +: W]);
    end
    drive(2'd0, '0, 1'b0, 4'b1101);
    checks++;
    if (bus.out_valid !== 4'b1010 || bus.out_data[3*W +: W] !== 2'b01) begin
      errors++;
      $display("FAIL ind_ch3 got=%b/%b exp=1010/01",
               bus.out_valid, bus.out_data[3*W +: W]);
    end
    checks++;
    if (bus.out_data[1*W +: W] !== 2'b11) begin
      errors++;
      $display("FAIL ind_ch1_data got=%b exp=11", bus.out_data[1*W +: W]);
    end
    drive(2'd0, '0, 1'b0, 4'hF);
    drive(2'd0, '0, 1'b0, 4'hF);
    checks++;
    if (bus.out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL ind_empty got=%b exp=0000", bus.out_valid);
    end
  endtask

  task automatic test_load_drain;
    drive(2'd0, 2'b01, 1'b1, 4'hF);
    drive(2'd0, 2'b11, 1'b1, 4'hF);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_data[0 +: W] !== 2'b01) begin
      errors++;
      $display("FAIL ld_ready got=%b/%b exp=1/01",
               bus.in_ready, bus.out_data[0 +: W]);
    end
    drive(2'd0, '0, 1'b0, 4'hF);
    checks++;
    if (bus.out_valid[0] !== 1'b1 || bus.out_data[0 +: W] !== 2'b11) begin
      errors++;
      $display("FAIL ld_next got=%b/%b exp=1/11",
               bus.out_valid[0], bus.out_data[0 +: W]);
    end
    drive(2'd0, '0, 1'b0, 4'hF);
  endtask

  task automatic test_random;
    logic [W-1:0] mq [4][$];
    logic [1:0]   sel;
    logic [W-1:0] d;
    logic         v, hold, exp_rdy;
    logic [3:0]   r;
    int           bad;
    hold = 1'b0; sel = 0; d = 0; v = 0;
    for (int k = 0; k < 4; k++) mq[k].delete();
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        sel = 2'($urandom);
        d   = W'($urandom);
        v   = ($urandom_range(0, 3) != 0);
      end
      r = 4'($urandom);
      drive(sel, d, v, r);
      bad = 0;
      for (int k = 0; k < 4; k++) begin
        if (bus.out_valid[k] !== (mq[k].size() != 0)) bad++;
        else if (mq[k].size() != 0 && bus.out_data[k*W +: W] !== mq[k][0]) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_out cyc=%0d got=%b/%h exp_sizes=%0d%0d%0d%0d",
                 c, bus.out_valid, bus.out_data,
                 mq[0].size(), mq[1].size(), mq[2].size(), mq[3].size());
      end
      exp_rdy = (mq[sel].size() == 0) || r[sel];
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, exp_rdy);
      end
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() != 0 && r[k]) void'(mq[k].pop_front());
      end
      if (v && exp_rdy) mq[sel].push_back(d);
      hold = v && !exp_rdy;
    end
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 4; k++) drive(2'(k), W'(k + 1), 1'b1, 4'h0);
    drive(2'd0, '0, 1'b0, 4'h0);
    checks++;
    if (bus.out_valid !== 4'b1111) begin
      errors++;
      $display("FAIL ar_fill got=%b exp=1111", bus.out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.out_data !== '0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ar_clear got=%b/%h/%b exp=0000/0/0",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd2, '0, 1'b0, 4'h0);
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_after got=%b/%b exp=0000/1", bus.out_valid, bus.in_ready);
    end
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counter;
    for (int i = 0; i < 257; i++) drive(2'd3, W'(i), 1'b1, 4'hF);
    drive(2'd0, '0, 1'b0, 4'hF);
    checks++;
    if (bus.out_cnt[3*CW +: CW] !== CW'(1)) begin
      errors++;
      $display("FAIL cnt_wrap got=%0d exp=1", bus.out_cnt[3*CW +: CW]);
    end
    checks++;
    if (bus.out_cnt[0 +: 3*CW] !== '0) begin
      errors++;
      $display("FAIL cnt_others got=%h exp=0", bus.out_cnt[0 +: 3*CW]);
    end
    for (int i = 0; i < 5; i++) drive(2'(i), W'(i), 1'b1, 4'h0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_cnt !== '0 || bus.out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL cnt_reset got=%h/%b exp=0/0000", bus.out_cnt, bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_independence();
    test_load_drain();
    test_random();
    test_async_reset();
`ifdef DEMUX_CNT_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
